pattern_sequence_detector: RTL and testbench

Parametrised successor to the fixed 4-state serial sequence detector. It compares a serial bit stream against a runtime-loadable pattern of PATTERN_LEN bits. A bit is sampled only on a rising edge of the update strobe. Overlapping or non-overlapping detection is selectable, and a saturating match counter is provided. It sits between a strobed serial source (button/debounce or UART-bit path) and status logic/LEDs.

---
 rtl/seq_det_pkg.sv | 33 +++
 rtl/rising_edge_detect.sv | 21 ++
 rtl/pattern_sequence_detector.sv | 99 +++++++++
 tb/tb_pattern_sequence_detector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration helpers for the serial pattern detector family.
package seq_det_pkg;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  localparam int unsigned MIN_PATTERN_LEN = 2;
  localparam int unsigned MAX_PATTERN_LEN = 16;
  localparam int unsigned MIN_COUNT_WIDTH = 1;
  localparam int unsigned MAX_COUNT_WIDTH = 16;

  // Bits needed to hold values 0..n-1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit pattern_len_legal(input int unsigned n);
    return (n >= MIN_PATTERN_LEN) && (n <= MAX_PATTERN_LEN);
  endfunction

  function automatic bit count_width_legal(input int unsigned n);
    return (n >= MIN_COUNT_WIDTH) && (n <= MAX_COUNT_WIDTH);
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Registered previous-value rising-edge detector for strobe inputs.
module rising_edge_detect
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset) prev_q <= LOW;
    else        prev_q <= in;
  end

  // Combinational: a strobe held high through reset release yields one pulse.
  assign pulse = in & ~prev_q;

endmodule

// File: rtl/pattern_sequence_detector.sv
// Serial bit-stream matcher against a runtime-loadable pattern, sampled on
// strobe rising edges, with optional overlap and a saturating match counter.
module pattern_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned                PATTERN_LEN     = 4,
  parameter logic [PATTERN_LEN-1:0]     DEFAULT_PATTERN = PATTERN_LEN'(4'b1011),
  parameter int unsigned                COUNT_WIDTH     = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 update,
  input  logic                                 value,
  input  logic [PATTERN_LEN-1:0]               pattern,
  input  logic                                 pattern_load,
  input  logic                                 overlap_en,
  input  logic                                 count_clear,
  output logic                                 sequence_detected,
  output logic [COUNT_WIDTH-1:0]               match_count,
  output logic [clog2(PATTERN_LEN+1)-1:0]      fill_level
);

  localparam int unsigned FILL_W = clog2(PATTERN_LEN + 1);
  localparam int unsigned HIST_W = PATTERN_LEN - 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [FILL_W-1:0]      FILL_FULL = FILL_W'(PATTERN_LEN);
  localparam logic [FILL_W-1:0]      FILL_ARM  = FILL_W'(PATTERN_LEN - 1);

  if (!pattern_len_legal(PATTERN_LEN)) begin : g_bad_pattern_len
    $error("pattern_sequence_detector: PATTERN_LEN must be 2..16");
  end
  if (!count_width_legal(COUNT_WIDTH)) begin : g_bad_count_width
    $error("pattern_sequence_detector: COUNT_WIDTH must be 1..16");
  end

  logic                   edge_event_c;
  logic [PATTERN_LEN-1:0] candidate_c;
  logic                   match_c;

  logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
  logic [HIST_W-1:0]      history_q, history_d;
  logic [FILL_W-1:0]      fill_q,    fill_d;
  logic                   det_q,     det_d;
  logic [COUNT_WIDTH-1:0] count_q,   count_d;

  rising_edge_detect u_update_edge (
    .clk   (clk),
    .reset (reset),
    .in    (update),
    .pulse (edge_event_c)
  );

  // Only the newest PATTERN_LEN-1 bits are kept; the new sample completes the window.
  assign candidate_c = {history_q, value};
  assign match_c     = (fill_q >= FILL_ARM) && (candidate_c == pattern_q);

  always_comb begin
    pattern_d = pattern_q;
    history_d = history_q;
    fill_d    = fill_q;
    det_d     = det_q;
    count_d   = count_q;

    if (pattern_load) begin
      pattern_d = pattern;
      fill_d    = '0;
      det_d     = LOW;
    end else if (edge_event_c) begin
      det_d     = match_c;
      history_d = candidate_c[HIST_W-1:0];
      if (match_c && !overlap_en) fill_d = '0;
      else if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
      if (match_c && (count_q != COUNT_MAX)) count_d = count_q + COUNT_WIDTH'(1);
    end

    if (count_clear) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pattern_q <= DEFAULT_PATTERN;
      history_q <= '0;
      fill_q    <= '0;
      det_q     <= LOW;
      count_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
      count_q   <= count_d;
    end
  end

  assign sequence_detected = det_q;
  assign match_count       = count_q;
  assign fill_level        = fill_q;

endmodule

// File: tb/tb_pattern_sequence_detector.sv
// Randomised and directed bench for pattern_sequence_detector against a
// queue-based reference model; a second instance exercises a 2-bit counter.
module tb_pattern_sequence_detector;

  logic       clk;
  logic       reset;
  logic       update;
  logic       value;
  logic [3:0] pattern;
  logic       pattern_load;
  logic       overlap_en;
  logic       count_clear;

  logic       det_a, det_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] fill_a, fill_b;

  int n_chk;
  int n_pass;

  // Reference model state
  bit       m_hist[$];
  bit [3:0] m_pat;
  bit       m_det;
  bit       m_prev;
  int       m_cnt8;
  int       m_cnt2;

  pattern_sequence_detector #(.PATTERN_LEN(4), .DEFAULT_PATTERN(4'b1011), .COUNT_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .update(update), .value(value), .pattern(pattern),
    .pattern_load(pattern_load), .overlap_en(overlap_en), .count_clear(count_clear),
    .sequence_detected(det_a), .match_count(cnt_a), .fill_level(fill_a)
  );

  pattern_sequence_detector #(.PATTERN_LEN(4), .DEFAULT_PATTERN(4'b1011), .COUNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .update(update), .value(value), .pattern(pattern),
    .pattern_load(pattern_load), .overlap_en(overlap_en), .count_clear(count_clear),
    .sequence_detected(det_b), .match_count(cnt_b), .fill_level(fill_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit ev;
    bit m;
    bit [3:0] cand;
    if (!reset) begin
      m_hist.delete();
      m_pat  = 4'b1011;
      m_det  = 1'b0;
      m_prev = 1'b0;
      m_cnt8 = 0;
      m_cnt2 = 0;
      return;
    end
    ev     = update && !m_prev;
    m_prev = update;
    if (pattern_load) begin
      m_pat = pattern;
      m_hist.delete();
      m_det = 1'b0;
    end else if (ev) begin
      m = 1'b0;
      if (m_hist.size() >= 3) begin
        cand = {m_hist[m_hist.size()-3], m_hist[m_hist.size()-2], m_hist[m_hist.size()-1], value};
        m = (cand == m_pat);
      end
      m_det = m;
      m_hist.push_back(value);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m && !overlap_en) m_hist.delete();
      if (m) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
    if (count_clear) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end
  endtask

  task automatic compare_all();
    check("det",      32'(det_a),  32'(m_det));
    check("count",    32'(cnt_a),  32'(m_cnt8));
    check("fill",     32'(fill_a), 32'(m_hist.size()));
    check("det_w2",   32'(det_b),  32'(m_det));
    check("count_w2", 32'(cnt_b),  32'(m_cnt2));
    check("fill_w2",  32'(fill_b), 32'(m_hist.size()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic apply_bit(input logic v);
    value  = v;
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
  endtask

  task automatic apply_bits(input logic [7:0] bits, input int n);
    logic [7:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) apply_bit(b[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic load_pattern(input logic [3:0] p);
    pattern      = p;
    pattern_load = 1'b1;
    tick();
    pattern_load = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0; update = 1'b0; value = 1'b0; pattern = 4'b0000;
    pattern_load = 1'b0; overlap_en = 1'b1; count_clear = 1'b0;

    do_reset();
    check("reset_det",   32'(det_a),  32'd0);
    check("reset_count", 32'(cnt_a),  32'd0);
    check("reset_fill",  32'(fill_a), 32'd0);

    // Default pattern, overlapping.
    overlap_en = 1'b1;
    apply_bits(8'b0000_1011, 4);
    check("t1_det_bit4", 32'(det_a), 32'd1);
    apply_bits(8'b0000_0011, 3);
    check("t1_det_bit7", 32'(det_a), 32'd1);
    check("t1_count",    32'(cnt_a), 32'd2);

    // Default pattern, non-overlapping.
    do_reset();
    overlap_en = 1'b0;
    apply_bits(8'b0101_1011, 7);
    check("t2_count", 32'(cnt_a),  32'd1);
    check("t2_fill",  32'(fill_a), 32'd3);

    // All-zero pattern, both overlap modes, and a long-held strobe.
    do_reset();
    load_pattern(4'b0000);
    overlap_en = 1'b1;
    apply_bits(8'h00, 6);
    check("t3_ovl_count", 32'(cnt_a), 32'd3);
    count_clear = 1'b1; tick(); count_clear = 1'b0;
    load_pattern(4'b0000);
    overlap_en = 1'b0;
    apply_bits(8'h00, 6);
    check("t3_novl_count", 32'(cnt_a), 32'd1);
    value = 1'b0; update = 1'b1;
    repeat (10) tick();
    update = 1'b0; tick();
    check("t3_hold_fill", 32'(fill_a), 32'd3);

    // Saturation of the 2-bit counter, then clear racing a match.
    do_reset();
    load_pattern(4'b0000);
    overlap_en = 1'b1;
    apply_bits(8'h00, 8);
    check("t4_sat_w2", 32'(cnt_b), 32'd3);
    check("t4_cnt_w8", 32'(cnt_a), 32'd5);
    value = 1'b0; update = 1'b1; count_clear = 1'b1;
    tick();
    update = 1'b0; count_clear = 1'b0;
    check("t4_clear_det", 32'(det_b), 32'd1);
    check("t4_clear_w2",  32'(cnt_b), 32'd0);
    tick();

    // Pattern load coinciding with an update edge.
    do_reset();
    overlap_en = 1'b1;
    apply_bits(8'b0000_0101, 3);
    value = 1'b1; update = 1'b1; pattern = 4'b1011; pattern_load = 1'b1;
    tick();
    pattern_load = 1'b0; update = 1'b0;
    check("t5_fill",  32'(fill_a), 32'd0);
    check("t5_det",   32'(det_a),  32'd0);
    check("t5_count", 32'(cnt_a),  32'd0);
    tick();
    apply_bits(8'b0000_0011, 3);
    check("t5_nomatch", 32'(det_a), 32'd0);

    // Reset mid-stream with update held across release.
    load_pattern(4'b0110);
    apply_bits(8'b0000_0110, 4);
    check("t6_pre_det", 32'(det_a), 32'd1);
    update = 1'b1; value = 1'b1; reset = 1'b0;
    tick();
    check("t6_rst_det",   32'(det_a),  32'd0);
    check("t6_rst_count", 32'(cnt_a),  32'd0);
    check("t6_rst_fill",  32'(fill_a), 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("t6_one_sample", 32'(fill_a), 32'd1);
    update = 1'b0; tick();
    apply_bits(8'b0000_0011, 3);
    check("t6_default_det",   32'(det_a), 32'd1);
    check("t6_default_count", 32'(cnt_a), 32'd1);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset        = ($urandom_range(0, 99) != 0);
      update       = $urandom_range(0, 1) == 1;
      value        = $urandom_range(0, 1) == 1;
      pattern      = 4'($urandom_range(0, 15));
      pattern_load = ($urandom_range(0, 39) == 0);
      overlap_en   = ($urandom_range(0, 3) != 0);
      count_clear  = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
